// File: rtl/i2c_shift_engine.sv
// SCL-strobe-driven serialiser/deserialiser for one I2C data byte plus its ACK slot.
// Runtime MSB/LSB-first order; abort returns to IDLE without signalling completion.
module i2c_shift_engine #(
  parameter  int DATA_WIDTH = 8,
  localparam int CW         = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_rw_mode,
  input  logic                  i_msb_first,
  input  logic                  i_ack_en,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_scl_rise,
  input  logic                  i_scl_fall,
  input  logic                  i_sda_in,
  output logic                  o_sda_out,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  o_ack_phase,
  output logic                  o_done,
  output logic                  o_ack_received,
  output logic [CW-1:0]         o_bit_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;

  state_t                state, state_nxt;
  logic                  rw_q, msb_q, ack_en_q;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [CW-1:0]         bit_cnt;
  logic                  done_q, ack_rcv_q;
  logic                  fall_eff, start_ok, cnt_full;

  // A fall coinciding with a rise is dropped so the rise always wins.
  assign fall_eff = i_scl_fall & ~i_scl_rise;
  assign start_ok = i_start & ~i_abort;
  assign cnt_full = (bit_cnt == CW'(DATA_WIDTH));

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_start) state_nxt = DATA;
        DATA:    if (fall_eff && cnt_full) state_nxt = ACK;
        ACK:     if (fall_eff) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_sda_out = 1'b1;
    case (state)
      DATA:    if (!rw_q) o_sda_out = msb_q ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
      ACK:     if (rw_q) o_sda_out = ~ack_en_q;
      default: o_sda_out = 1'b1;
    endcase
  end

  assign o_busy         = (state != IDLE);
  assign o_ack_phase    = (state == ACK);
  assign o_done         = done_q;
  assign o_ack_received = ack_rcv_q;
  assign o_rx_data      = rx_q;
  assign o_bit_cnt      = bit_cnt;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt   <= '0;
      done_q    <= 1'b0;
      ack_rcv_q <= 1'b0;
      rx_q      <= '0;
      rw_q      <= 1'b0;
      msb_q     <= 1'b1;
      ack_en_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_abort) begin
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (i_start) begin
            rw_q      <= i_rw_mode;
            msb_q     <= i_msb_first;
            ack_en_q  <= i_ack_en;
            bit_cnt   <= '0;
            ack_rcv_q <= 1'b0;
          end
          DATA: begin
            if (i_scl_rise && !cnt_full) bit_cnt <= bit_cnt + CW'(1);
            if (fall_eff && cnt_full && rw_q) rx_q <= shift_reg;
          end
          ACK: begin
            if (i_scl_rise && !rw_q) ack_rcv_q <= ~i_sda_in;
            if (fall_eff) done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Shift register is pure datapath; it is only observed while out of IDLE.
  always_ff @(posedge i_sys_clk) begin
    if (state == IDLE) begin
      if (start_ok) shift_reg <= i_rw_mode ? '0 : i_tx_data;
    end else if (state == DATA && !i_abort) begin
      if (rw_q) begin
        if (i_scl_rise && !cnt_full)
          shift_reg <= msb_q ? {shift_reg[DATA_WIDTH-2:0], i_sda_in}
                             : {i_sda_in, shift_reg[DATA_WIDTH-1:1]};
      end else if (fall_eff) begin
        shift_reg <= msb_q ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                           : {1'b0, shift_reg[DATA_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_i2c_shift_engine.sv
// Bench for i2c_shift_engine: an 8-bit and a 12-bit instance driven by shared SCL strobes,
// checked against a word/bit-order model of the transfer.
module tb_i2c_shift_engine;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start8 = 1'b0, start12 = 1'b0, abort = 1'b0;
  logic        rw = 1'b0, msb = 1'b1, ack_en = 1'b0;
  logic        rise = 1'b0, fall = 1'b0, sda_in = 1'b1;
  logic [11:0] tx_data = '0;

  logic       sda8, busy8, ackph8, done8, ackr8;
  logic [7:0] rx8;
  logic [3:0] cnt8;
  logic        sda12, busy12, ackph12, done12, ackr12;
  logic [11:0] rx12;
  logic [3:0]  cnt12;

  int checks = 0, errors = 0;
  int done_cnt8 = 0, done_cnt12 = 0;
  bit sel12 = 1'b0;
  logic [11:0] exp_rx [2];
  logic        exp_ackr [2];

  i2c_shift_engine #(.DATA_WIDTH(8)) dut8 (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_abort(abort),
    .i_rw_mode(rw), .i_msb_first(msb), .i_ack_en(ack_en), .i_tx_data(tx_data[7:0]),
    .i_scl_rise(rise), .i_scl_fall(fall), .i_sda_in(sda_in), .o_sda_out(sda8),
    .o_rx_data(rx8), .o_busy(busy8), .o_ack_phase(ackph8), .o_done(done8),
    .o_ack_received(ackr8), .o_bit_cnt(cnt8));

  i2c_shift_engine #(.DATA_WIDTH(12)) dut12 (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start12), .i_abort(abort),
    .i_rw_mode(rw), .i_msb_first(msb), .i_ack_en(ack_en), .i_tx_data(tx_data),
    .i_scl_rise(rise), .i_scl_fall(fall), .i_sda_in(sda_in), .o_sda_out(sda12),
    .o_rx_data(rx12), .o_busy(busy12), .o_ack_phase(ackph12), .o_done(done12),
    .o_ack_received(ackr12), .o_bit_cnt(cnt12));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done8)  done_cnt8++;
    if (done12) done_cnt12++;
  end

  wire        c_sda   = sel12 ? sda12   : sda8;
  wire        c_busy  = sel12 ? busy12  : busy8;
  wire        c_ackph = sel12 ? ackph12 : ackph8;
  wire        c_done  = sel12 ? done12  : done8;
  wire        c_ackr  = sel12 ? ackr12  : ackr8;
  wire [3:0]  c_cnt   = sel12 ? cnt12   : cnt8;
  wire [11:0] c_rx    = sel12 ? rx12    : {4'b0, rx8};

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Bit k on the wire for a word d of width w.
  function automatic logic wire_bit(logic [11:0] d, int w, bit m, int k);
    return m ? d[w-1-k] : d[k];
  endfunction

  task automatic start_xfer(input bit r, input bit m, input bit a, input logic [11:0] d);
    rw = r; msb = m; ack_en = a; tx_data = d;
    if (sel12) start12 = 1'b1; else start8 = 1'b1;
    cycle();
    start8 = 1'b0; start12 = 1'b0;
    rw = 1'($urandom); msb = 1'($urandom); ack_en = 1'($urandom); tx_data = 12'($urandom);
  endtask

  // stop_at >= 0 interrupts before bit stop_at: kind 0 = abort, kind 1 = async reset.
  task automatic run_xfer(input string nm, input bit r, input bit m, input bit a,
                          input logic [11:0] d, input bit ack_sda, input int stop_at,
                          input int stop_kind, input bit ovl, input bit poke);
    int w, idx;
    logic [11:0] dm;
    logic eb;
    w  = sel12 ? 12 : 8;
    idx = sel12 ? 1 : 0;
    dm = d & 12'((1 << w) - 1);
    start_xfer(r, m, a, d);
    exp_ackr[idx] = 1'b0;
    checks++; if (c_busy !== 1'b1) begin errors++; $display("FAIL %s busy after start: got %b want 1", nm, c_busy); end
    checks++; if (c_ackr !== 1'b0) begin errors++; $display("FAIL %s ack_received cleared by start: got %b want 0", nm, c_ackr); end
    for (int k = 0; k < w; k++) begin
      if (k == stop_at) begin
        if (stop_kind == 0) begin
          abort = 1'b1; cycle(); abort = 1'b0;
          checks++; if (c_busy !== 1'b0 || c_sda !== 1'b1 || c_cnt !== 4'd0 || c_ackph !== 1'b0)
            begin errors++; $display("FAIL %s abort state: got busy=%b sda=%b cnt=%0d ackph=%b want 0 1 0 0", nm, c_busy, c_sda, c_cnt, c_ackph); end
          checks++; if (c_rx !== exp_rx[idx] || c_ackr !== exp_ackr[idx])
            begin errors++; $display("FAIL %s abort hold: got rx=%h ackr=%b want %h %b", nm, c_rx, c_ackr, exp_rx[idx], exp_ackr[idx]); end
        end else begin
          #2 rst_n = 1'b0; #1;
          checks++; if (sda8 !== 1'b1 || rx8 !== 8'h0 || busy8 !== 1'b0 || ackph8 !== 1'b0 ||
                        done8 !== 1'b0 || ackr8 !== 1'b0 || cnt8 !== 4'd0 || c_sda !== 1'b1 || c_rx !== 12'h0 || c_busy !== 1'b0)
            begin errors++; $display("FAIL %s reset mid-transfer: got sda=%b rx=%h busy=%b ackph=%b done=%b ackr=%b cnt=%0d want 1 0 0 0 0 0 0", nm, c_sda, c_rx, c_busy, c_ackph, c_done, c_ackr, c_cnt); end
          cycle(); rst_n = 1'b1; cycle();
          exp_rx[0] = '0; exp_rx[1] = '0; exp_ackr[0] = 1'b0; exp_ackr[1] = 1'b0;
        end
        return;
      end
      if (poke && k == 2) begin
        tx_data = ~d; rw = ~r;
        if (sel12) start12 = 1'b1; else start8 = 1'b1;
        cycle();
        start8 = 1'b0; start12 = 1'b0;
      end
      eb = wire_bit(dm, w, m, k);
      checks++; if (c_sda !== (r ? 1'b1 : eb)) begin errors++; $display("FAIL %s sda bit%0d: got %b want %b", nm, k, c_sda, r ? 1'b1 : eb); end
      sda_in = eb; rise = 1'b1;
      if (ovl && k[0]) fall = 1'b1;
      cycle();
      rise = 1'b0; fall = 1'b0; sda_in = 1'($urandom);
      checks++; if (c_cnt !== 4'(k + 1) || c_sda !== (r ? 1'b1 : eb))
        begin errors++; $display("FAIL %s after rise %0d: got cnt=%0d sda=%b want %0d %b", nm, k, c_cnt, c_sda, k + 1, r ? 1'b1 : eb); end
      if (ovl && k == w - 1) begin
        sda_in = ~eb; rise = 1'b1; fall = 1'b1; cycle(); rise = 1'b0; fall = 1'b0;
        checks++; if (c_cnt !== 4'(w) || c_ackph !== 1'b0)
          begin errors++; $display("FAIL %s extra rise+fall: got cnt=%0d ackph=%b want %0d 0", nm, c_cnt, c_ackph, w); end
      end
      cycle();
      fall = 1'b1; cycle(); fall = 1'b0;
    end
    if (r) exp_rx[idx] = dm;
    checks++; if (c_ackph !== 1'b1 || c_sda !== (r ? ~a : 1'b1))
      begin errors++; $display("FAIL %s ack slot: got ackph=%b sda=%b want 1 %b", nm, c_ackph, c_sda, r ? ~a : 1'b1); end
    sda_in = ack_sda; rise = 1'b1; cycle(); rise = 1'b0; sda_in = 1'($urandom);
    cycle();
    fall = 1'b1; cycle(); fall = 1'b0;
    if (!r) exp_ackr[idx] = ~ack_sda;
    checks++; if (c_done !== 1'b1 || c_busy !== 1'b0 || c_sda !== 1'b1 || c_ackph !== 1'b0)
      begin errors++; $display("FAIL %s completion: got done=%b busy=%b sda=%b ackph=%b want 1 0 1 0", nm, c_done, c_busy, c_sda, c_ackph); end
    checks++; if (c_rx !== exp_rx[idx] || c_ackr !== exp_ackr[idx])
      begin errors++; $display("FAIL %s result: got rx=%h ackr=%b want %h %b", nm, c_rx, c_ackr, exp_rx[idx], exp_ackr[idx]); end
  endtask

  task automatic test_reset();
    cycle(); cycle();
    checks++; if (sda8 !== 1'b1 || rx8 !== 8'h0 || busy8 !== 1'b0 || ackph8 !== 1'b0 || done8 !== 1'b0 || ackr8 !== 1'b0 || cnt8 !== 4'd0)
      begin errors++; $display("FAIL reset8: got sda=%b rx=%h busy=%b ackph=%b done=%b ackr=%b cnt=%0d", sda8, rx8, busy8, ackph8, done8, ackr8, cnt8); end
    rst_n = 1'b1; cycle();
    checks++; if (sda12 !== 1'b1 || rx12 !== 12'h0 || busy12 !== 1'b0 || ackph12 !== 1'b0 || done12 !== 1'b0 || ackr12 !== 1'b0 || cnt12 !== 4'd0)
      begin errors++; $display("FAIL reset12: got sda=%b rx=%h busy=%b ackph=%b done=%b ackr=%b cnt=%0d", sda12, rx12, busy12, ackph12, done12, ackr12, cnt12); end
  endtask

  task automatic test_tx_msb_a5();
    int d0;
    sel12 = 1'b0; d0 = done_cnt8;
    run_xfer("tx_a5", 1'b0, 1'b1, 1'b0, 12'h0A5, 1'b0, -1, 0, 1'b0, 1'b0);
    cycle();
    checks++; if (done_cnt8 - d0 !== 1) begin errors++; $display("FAIL tx_a5 done pulses: got %0d want 1", done_cnt8 - d0); end
  endtask

  task automatic test_rx_lsb_53();
    int d0;
    sel12 = 1'b0; d0 = done_cnt8;
    run_xfer("rx_53", 1'b1, 1'b0, 1'b0, 12'h053, 1'b0, -1, 0, 1'b0, 1'b0);
    cycle();
    checks++; if (rx8 !== 8'h53 || done_cnt8 - d0 !== 1)
      begin errors++; $display("FAIL rx_53 word/done: got %h %0d want 53 1", rx8, done_cnt8 - d0); end
  endtask

  task automatic test_tx_nack();
    sel12 = 1'b0;
    run_xfer("tx_ack", 1'b0, 1'($urandom), 1'b0, 12'($urandom), 1'b0, -1, 0, 1'b0, 1'b0);
    run_xfer("tx_nack", 1'b0, 1'($urandom), 1'b0, 12'($urandom), 1'b1, -1, 0, 1'b0, 1'b0);
    cycle();
  endtask

  task automatic test_abort();
    int d0;
    sel12 = 1'b0; d0 = done_cnt8;
    run_xfer("abort", 1'b0, 1'b1, 1'b0, 12'($urandom), 1'b0, 4, 0, 1'b0, 1'b0);
    cycle(); cycle();
    checks++; if (done_cnt8 != d0) begin errors++; $display("FAIL abort done pulses: got %0d want 0", done_cnt8 - d0); end
  endtask

  task automatic test_rx12_overlap();
    sel12 = 1'b1;
    run_xfer("rx12_c3a", 1'b1, 1'b1, 1'b1, 12'hC3A, 1'b0, -1, 0, 1'b1, 1'b0);
    cycle();
    checks++; if (rx12 !== 12'hC3A) begin errors++; $display("FAIL rx12 word: got %h want c3a", rx12); end
    run_xfer("tx12_ovl", 1'b0, 1'b0, 1'b0, 12'($urandom), 1'b1, -1, 0, 1'b1, 1'b0);
    cycle();
  endtask

  task automatic test_back_to_back();
    int d8, d12;
    d8 = done_cnt8; d12 = done_cnt12;
    sel12 = 1'b0;
    for (int i = 0; i < 5; i++)
      run_xfer("b2b8", 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom), 1'($urandom), -1, 0, 1'($urandom), 1'b0);
    cycle();
    sel12 = 1'b1;
    for (int i = 0; i < 3; i++)
      run_xfer("b2b12", 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom), 1'($urandom), -1, 0, 1'b0, 1'b0);
    cycle();
    checks++; if (done_cnt8 - d8 !== 5 || done_cnt12 - d12 !== 3)
      begin errors++; $display("FAIL b2b done pulses: got %0d/%0d want 5/3", done_cnt8 - d8, done_cnt12 - d12); end
  endtask

  task automatic test_start_ignored();
    sel12 = 1'b0;
    run_xfer("busy_start", 1'b0, 1'b1, 1'b0, 12'($urandom), 1'b0, -1, 0, 1'b0, 1'b1);
    run_xfer("busy_start_rx", 1'b1, 1'b0, 1'b1, 12'($urandom), 1'b0, -1, 0, 1'b0, 1'b1);
    cycle();
    start8 = 1'b1; start12 = 1'b1; abort = 1'b1; cycle();
    start8 = 1'b0; start12 = 1'b0; abort = 1'b0;
    checks++; if (busy8 !== 1'b0 || busy12 !== 1'b0 || cnt8 !== 4'd0)
      begin errors++; $display("FAIL start+abort: got busy8=%b busy12=%b cnt8=%0d want 0 0 0", busy8, busy12, cnt8); end
  endtask

  task automatic test_reset_mid_rx();
    sel12 = 1'b0;
    run_xfer("rx_pre", 1'b1, 1'b1, 1'b1, 12'h0C6, 1'b0, -1, 0, 1'b0, 1'b0);
    cycle();
    run_xfer("rst_mid_rx", 1'b1, 1'b1, 1'b0, 12'($urandom), 1'b0, 5, 1, 1'b0, 1'b0);
    run_xfer("after_rst", 1'b0, 1'b1, 1'b0, 12'($urandom), 1'b0, -1, 0, 1'b0, 1'b0);
    cycle();
  endtask

  initial begin
    exp_rx[0] = '0; exp_rx[1] = '0; exp_ackr[0] = 1'b0; exp_ackr[1] = 1'b0;
    test_reset();
    test_tx_msb_a5();
    test_rx_lsb_53();
    test_tx_nack();
    test_abort();
    test_rx12_overlap();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_rx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
